// File: rtl/accel_tenths_bcd.sv
// accel_tenths_bcd
//   Averages 2^AVG_LOG2 signed accelerometer samples (256 LSB/g) and reports
//   the magnitude of the mean in tenths of a g as three BCD digits plus a sign.
//
//   Ports
//     iCLK       single clock
//     iRST       asynchronous active-high reset
//     iDATA      signed 16-bit sample, valid while iVALID is high
//     iVALID     one-cycle sample strobe
//     oSIGN      1 = negative result (a result that rounds to 0.0 is positive)
//     oD2/oD1/oD0  BCD tens of g / units of g / tenths of g
//     oVALID     one-cycle pulse when oSIGN/oD* carry a new result
//     oBUSY      high while a result is being computed (SCALE, CONV, OUT)
//     oOVR       sticky: a sample arrived while busy and was dropped
//     dbg_state  current FSM state (ACC=0, SCALE=1, CONV=2, OUT=3)
//
//   Handshake: iVALID is a strobe with no back-pressure. A sample is taken only
//   when iVALID=1 and oBUSY=0 in the same cycle; iVALID while oBUSY=1 drops the
//   sample and sets oOVR. oVALID is a one-cycle pulse with no ready; the result
//   outputs hold until the next pulse.
module accel_tenths_bcd #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [15:0] iDATA,
  input  logic        iVALID,
  output logic        oSIGN,
  output logic [3:0]  oD2,
  output logic [3:0]  oD1,
  output logic [3:0]  oD0,
  output logic        oVALID,
  output logic        oBUSY,
  output logic        oOVR,
  output logic [1:0]  dbg_state
);

  localparam int AW   = 16 + AVG_LOG2;
  localparam int CW   = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int LAST = (1 << AVG_LOG2) - 1;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    SCALE = 2'd1,
    CONV  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t             state;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]      cnt;
  logic signed [15:0] mean;
  logic               sign_r;
  logic [7:0]         bin;
  logic [11:0]        bcd;
  logic [2:0]         bit_cnt;

  // Accumulate path: AW bits hold 2^AVG_LOG2 full-scale samples without overflow.
  logic signed [AW-1:0] sum;
  logic signed [15:0]   mean_next;
  logic                 last_sample;

  always_comb begin
    sum         = acc + AW'($signed(iDATA));
    mean_next   = 16'(sum >>> AVG_LOG2);
    last_sample = (cnt == CW'(LAST));
  end

  // Scale path: |mean| needs 17 bits so that -32768 maps to +32768.
  logic [16:0] mean_ext;
  logic [16:0] mag;
  logic [20:0] prod;
  logic [12:0] tenths_full;
  logic [7:0]  tenths8;

  always_comb begin
    mean_ext    = {mean[15], mean};
    mag         = mean[15] ? (~mean_ext + 17'd1) : mean_ext;
    prod        = {4'd0, mag} * 21'd10 + 21'd128;
    tenths_full = 13'(prod >> 8);
    tenths8     = (tenths_full > 13'd199) ? 8'd199 : tenths_full[7:0];
  end

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
  logic [11:0] adj;
  logic [19:0] sh;
  logic [11:0] bcd_n;
  logic [7:0]  bin_n;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    sh    = {adj, bin} << 1;
    bcd_n = sh[19:8];
    bin_n = sh[7:0];
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      mean    <= '0;
      sign_r  <= 1'b0;
      bin     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      oSIGN   <= 1'b0;
      oD2     <= '0;
      oD1     <= '0;
      oD0     <= '0;
      oVALID  <= 1'b0;
      oOVR    <= 1'b0;
    end else begin
      if (iVALID && (state != ACC)) oOVR <= 1'b1;

      case (state)
        ACC: begin
          if (iVALID) begin
            if (last_sample) begin
              mean  <= mean_next;
              acc   <= '0;
              cnt   <= '0;
              state <= SCALE;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        SCALE: begin
          bin     <= tenths8;
          bcd     <= '0;
          bit_cnt <= '0;
          sign_r  <= mean[15] && (tenths8 != 8'd0);
          state   <= CONV;
        end
        CONV: begin
          bcd     <= bcd_n;
          bin     <= bin_n;
          bit_cnt <= bit_cnt + 3'd1;
          // The eighth shift completes the conversion; publish its result so
          // the registered outputs are live during the OUT cycle.
          if (bit_cnt == 3'd7) begin
            oSIGN  <= sign_r;
            oD2    <= bcd_n[11:8];
            oD1    <= bcd_n[7:4];
            oD0    <= bcd_n[3:0];
            oVALID <= 1'b1;
            state  <= OUT;
          end
        end
        OUT: begin
          oVALID <= 1'b0;
          state  <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

  assign oBUSY     = (state != ACC);
  assign dbg_state = state;

endmodule

// File: tb/tb_accel_tenths_bcd.sv
module tb_accel_tenths_bcd;

  // ---------------- clock / reset ----------------
  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  // DUT with AVG_LOG2 = 2 (model-checked every cycle)
  logic [15:0] iDATA = '0;
  logic        iVALID = 1'b0;
  logic        oSIGN, oVALID, oBUSY, oOVR;
  logic [3:0]  oD2, oD1, oD0;
  logic [1:0]  dbg_state;

  // DUT with AVG_LOG2 = 0 (directed checks)
  logic [15:0] dat0 = '0;
  logic        v0 = 1'b0;
  logic        s0, val0, busy0, ovr0;
  logic [3:0]  a0, b0, c0;
  logic [1:0]  st0;

  accel_tenths_bcd #(.AVG_LOG2(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iVALID(iVALID),
    .oSIGN(oSIGN), .oD2(oD2), .oD1(oD1), .oD0(oD0),
    .oVALID(oVALID), .oBUSY(oBUSY), .oOVR(oOVR), .dbg_state(dbg_state)
  );

  accel_tenths_bcd #(.AVG_LOG2(0)) dut0 (
    .iCLK(iCLK), .iRST(iRST), .iDATA(dat0), .iVALID(v0),
    .oSIGN(s0), .oD2(a0), .oD1(b0), .oD0(c0),
    .oVALID(val0), .oBUSY(busy0), .oOVR(ovr0), .dbg_state(st0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Result packed as {sign, d2, d1, d0}.
  function automatic logic [12:0] model_result(input int sum, input int n);
    int q, mag, t;
    logic s;
    q = sum / n;
    if ((sum % n) != 0 && sum < 0) q = q - 1;   // floor division
    mag = (q < 0) ? -q : q;
    t = (mag * 10 + 128) / 256;
    if (t > 199) t = 199;
    s = (q < 0) && (t != 0);
    return {s, 4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  int          due_q[$];
  int          edge_n = 0;        // index of the next rising edge
  int          busy_from = -100;
  int          busy_to = -100;
  int          samp_sum = 0;
  int          samp_n = 0;
  logic        m_ovr = 1'b0;
  logic [12:0] held = '0;

  // At each falling edge: check the state produced by the previous rising
  // edge, then fold in the inputs that the next rising edge will sample.
  always @(negedge iCLK) begin
    int  last;
    bit  exp_v, exp_busy;
    last = edge_n - 1;
    if (iRST) begin
      check("rst_sign", oSIGN, 0);
      check("rst_d2", oD2, 0);
      check("rst_d1", oD1, 0);
      check("rst_d0", oD0, 0);
      check("rst_valid", oVALID, 0);
      check("rst_busy", oBUSY, 0);
      check("rst_ovr", oOVR, 0);
      exp_q.delete();
      due_q.delete();
      busy_from = -100;
      busy_to = -100;
      samp_sum = 0;
      samp_n = 0;
      m_ovr = 1'b0;
      held = '0;
    end else begin
      exp_v = (due_q.size() > 0) && (due_q[0] == last);
      exp_busy = (last >= busy_from) && (last <= busy_to);
      check("valid", oVALID, exp_v);
      check("busy", oBUSY, exp_busy);
      check("ovr", oOVR, m_ovr);
      if (exp_v) begin
        held = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      check("out_sign", oSIGN, held[12]);
      check("out_d2", oD2, held[11:8]);
      check("out_d1", oD1, held[7:4]);
      check("out_d0", oD0, held[3:0]);

      if (iVALID) begin
        if (exp_busy) begin
          m_ovr = 1'b1;
        end else begin
          samp_sum += int'($signed(iDATA));
          samp_n++;
          if (samp_n == 4) begin
            exp_q.push_back(model_result(samp_sum, 4));
            due_q.push_back(edge_n + 9);
            busy_from = edge_n;
            busy_to = edge_n + 9;
            samp_sum = 0;
            samp_n = 0;
          end
        end
      end
    end
    edge_n++;
  end

  // ---------------- driver tasks ----------------
  // All drivers are called at posedge+1 and return at posedge+1.
  task automatic send(input logic [15:0] d);
    iVALID = 1'b1;
    iDATA = d;
    @(posedge iCLK); #1;
    iVALID = 1'b0;
  endtask

  task automatic send0(input logic [15:0] d);
    v0 = 1'b1;
    dat0 = d;
    @(posedge iCLK); #1;
    v0 = 1'b0;
  endtask

  // Counts falling edges from the return of the completing send until oVALID.
  task automatic wait_out(input bit which, output int lat, output logic [12:0] res);
    lat = 0;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge iCLK);
      if (which ? val0 : oVALID) begin
        lat = i;
        res = which ? {s0, a0, b0, c0} : {oSIGN, oD2, oD1, oD0};
        break;
      end
    end
    if (lat == 0) check("timeout", 0, 1);
    @(posedge iCLK); #1;
  endtask

  task automatic run_group(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input logic [12:0] exp, input bit chk_lat);
    int lat;
    logic [12:0] res;
    send(a);
    send(b);
    send(c);
    send(d);
    wait_out(1'b0, lat, res);
    check({name, "_result"}, res, exp);
    if (chk_lat) check({name, "_latency"}, lat, 10);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    logic [12:0] res;

    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    @(posedge iCLK); #1;

    // Hand values pinning the model itself.
    check("model_101", model_result(406, 4), 13'h0_004);
    check("model_neg0", model_result(-5, 4), 13'h0_000);
    check("model_clamp", model_result(-131072, 4), 13'h1_199);

    run_group("one_g", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 13'h0_010, 1'b1);
    run_group("neg_one_g", 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 13'h1_010, 1'b1);
    run_group("max_clamp", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 13'h0_199, 1'b1);
    run_group("mean101", 16'd100, 16'd101, 16'd102, 16'd103, 13'h0_004, 1'b1);
    run_group("neg_zero", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 13'h0_000, 1'b1);
    run_group("min_clamp", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 13'h1_199, 1'b1);
    run_group("mixed", 16'h0300, 16'h0280, 16'h0200, 16'h0100, 13'h0_021, 1'b1);

    // Sample dropped during CONV.
    check("ovr_before", oOVR, 0);
    send(16'h0100); send(16'h0100); send(16'h0100); send(16'h0100);
    repeat (3) @(posedge iCLK);
    #1;
    send(16'h0500);
    wait_out(1'b0, lat, res);
    check("drop_result", res, 13'h0_010);
    check("ovr_set", oOVR, 1);
    run_group("after_drop", 16'h0300, 16'h0300, 16'h0300, 16'h0300, 13'h0_030, 1'b1);
    check("ovr_sticky", oOVR, 1);

    // AVG_LOG2 = 0 instance: one result per sample.
    send0(16'h8000);
    wait_out(1'b1, lat, res);
    check("avg0_min", res, 13'h1_199);
    check("avg0_latency", lat, 10);
    send0(16'h0180);
    wait_out(1'b1, lat, res);
    check("avg0_1p5", res, 13'h0_015);
    check("avg0_latency2", lat, 10);
    check("avg0_ovr", ovr0, 0);

    // Reset three cycles into CONV aborts the result.
    send(16'h0100); send(16'h0100); send(16'h0100); send(16'h0100);
    repeat (4) @(posedge iCLK);
    #1 iRST = 1'b1;
    #1;
    check("abort_sign", oSIGN, 0);
    check("abort_digits", {oD2, oD1, oD0}, 0);
    check("abort_busy", oBUSY, 0);
    check("abort_ovr", oOVR, 0);
    check("abort_valid", oVALID, 0);
    check("abort_avg0_digits", {s0, a0, b0, c0}, 0);
    @(posedge iCLK); #1 iRST = 1'b0;
    repeat (15) @(posedge iCLK);
    #1;
    // Three leftover-free samples then one more: first result needs all four.
    run_group("post_reset", 16'h0200, 16'h0200, 16'h0200, 16'h0200, 13'h0_020, 1'b1);
    check("post_reset_ovr", oOVR, 0);

    repeat (5) @(posedge iCLK);
    #1;
    check("pending_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
